// File: rtl/aucohl_fifo_tx.sv
// aucohl_fifo_tx: drains a FWFT FIFO into LSB-first start/data/[parity]/stop frames, one pop per frame, tx low the cycle after the pop.
// Bit period latched from clk_div at each pop; waits in IDLE while the FIFO is empty or en=0; AUCOHL_FIFO_TX_PARITY_EN adds an even-parity bit.
module aucohl_fifo_tx #(
  parameter int DW = 8,
  parameter int W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [W-1:0]  clk_div,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_rdata,
  output logic          fifo_rd,
  output logic          tx,
  output logic          busy
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [W-1:0]  ONE_W    = W'(1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

`ifdef AUCOHL_FIFO_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [W-1:0]  per_q, per_d;
  logic [W-1:0]  tmr_q, tmr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          pop;
  logic          bit_end;
`ifdef AUCOHL_FIFO_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    per_d   = per_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    tx_d    = 1'b1;
    busy_d  = 1'b0;
    pop     = 1'b0;
    bit_end = (tmr_q == '0);
`ifdef AUCOHL_FIFO_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (en && !fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          per_d   = (clk_div == '0) ? ONE_W : clk_div;
          tmr_d   = per_d - ONE_W;
          cnt_d   = '0;
          state_d = START;
`ifdef AUCOHL_FIFO_TX_PARITY_EN
          par_d   = ^fifo_rdata;
`endif
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + ONE_C;
          if (cnt_q == LAST_BIT) begin
`ifdef AUCOHL_FIFO_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef AUCOHL_FIFO_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // every bit reloads P-1 so each one lasts exactly P cycles
    if (state_q != IDLE) begin
      tmr_d = bit_end ? (per_q - ONE_W) : (tmr_q - ONE_W);
    end

    // tx/busy are registered from the next state so they line up with it
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef AUCOHL_FIFO_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      per_q   <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef AUCOHL_FIFO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      per_q   <= per_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef AUCOHL_FIFO_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // the pop is combinational, so it must be held off explicitly during reset
  assign fifo_rd = pop & rst_n;
  assign tx      = tx_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_aucohl_fifo_tx.sv
// Scoreboard bench for aucohl_fifo_tx: words pushed into a modelled FIFO are expected on tx, bit by bit, when popped.
module tb_aucohl_fifo_tx;

  localparam int DW = 8;
  localparam int W  = 16;
`ifdef AUCOHL_FIFO_TX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [W-1:0]  clk_div;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rd;
  logic          tx;
  logic          busy;

  aucohl_fifo_tx #(.DW(DW), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clk_div    (clk_div),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  int last_pop = 0;
  int prev_pop = 0;
  bit in_frame = 1'b0;

  logic [DW-1:0] mem [64];
  int wp = 0;
  int rp = 0;
  logic [DW-1:0] sb [$];

  assign fifo_empty = (wp == rp);
  assign fifo_rdata = mem[rp[5:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wp[5:0]] = w;
    sb.push_back(w);
    wp++;
  endtask

  // FIFO model advances its read pointer just after the edge that consumed the pop
  always @(negedge clk) begin
    if (fifo_rd) begin
      @(posedge clk);
      #1;
      rp++;
    end
  end

  task automatic run_frame();
    logic [DW-1:0] w;
    logic          seq [NB];
    int            p;
    bit            abort;
    in_frame = 1'b1;
    abort    = 1'b0;
    prev_pop = last_pop;
    last_pop = cyc;
    pops++;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'(sb.size()), 1);
      in_frame = 1'b0;
      return;
    end
    w = sb.pop_front();
    p = (clk_div == '0) ? 1 : int'(clk_div);
    seq[0] = 1'b0;
    for (int i = 0; i < DW; i++) seq[i+1] = w[i];
`ifdef AUCOHL_FIFO_TX_PARITY_EN
    seq[DW+1] = ^w;
`endif
    seq[NB-1] = 1'b1;
    for (int b = 0; b < NB && !abort; b++) begin
      for (int c = 0; c < p && !abort; c++) begin
        @(negedge clk);
        if (!rst_n) begin
          abort = 1'b1;
          chk("abort_tx", tx, 1);
          chk("abort_busy", busy, 0);
          chk("abort_rd", fifo_rd, 0);
        end else begin
          chk("bit_tx", tx, seq[b]);
          chk("bit_busy", busy, 1);
          chk("bit_rd", fifo_rd, 0);
        end
      end
    end
    in_frame = 1'b0;
  endtask

  initial begin : monitor
    logic exp_rd;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd", fifo_rd, 0);
      end else begin
        exp_rd = en && (wp != rp);
        chk("idle_tx", tx, 1);
        chk("idle_busy", busy, 0);
        chk("idle_rd", fifo_rd, exp_rd);
        if (fifo_rd) run_frame();
      end
    end
  end

  task automatic wait_pop(input int target, input int budget);
    int n = 0;
    while (pops < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("pop_seen", (pops >= target), 1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((wp != rp || in_frame) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain", (n < budget), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    rst_n   = 1'b0;
    en      = 1'b0;
    clk_div = 16'd4;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rd", fifo_rd, 0);
    rst_n = 1'b1;

    // empty FIFO with en=1 stays idle
    en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("empty_no_pop", pops, 0);

    // single frame 0xA5, P=4
    push(8'hA5);
    wait_done(300);
    chk("single_pops", pops, 1);

    // back-to-back, P=1
    clk_div = 16'd1;
    push(8'h00);
    push(8'hFF);
    wait_done(300);
    chk("b2b_pops", pops, 3);
    chk("b2b_gap", last_pop - prev_pop, NB + 1);
    repeat (10) @(posedge clk);
    #1;
    chk("b2b_no_extra", pops, 3);

    // clk_div=0 behaves as 1
    clk_div = 16'd0;
    push(8'h3C);
    push(8'hC3);
    wait_done(300);
    chk("div0_pops", pops, 5);
    chk("div0_gap", last_pop - prev_pop, NB + 1);

    // clk_div 4 -> 8 mid-frame only affects the next frame
    clk_div = 16'd4;
    push(8'h5A);
    push(8'h96);
    wait_pop(6, 50);
    repeat (10) @(posedge clk);
    #1;
    clk_div = 16'd8;
    wait_done(600);
    chk("div_chg_pops", pops, 7);
    chk("div_chg_gap", last_pop - prev_pop, NB * 4 + 1);

    // en dropped during bit 3: frame completes, no further pop
    clk_div = 16'd4;
    base = pops;
    push(8'h0F);
    push(8'hF0);
    wait_pop(base + 1, 50);
    repeat (18) @(posedge clk);
    #1;
    en = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("en_drop_pops", pops, base + 1);
    chk("en_drop_left", wp - rp, 1);
    en = 1'b1;
    wait_done(300);
    chk("en_resume_pops", pops, base + 2);

    // reset during bit 5: popped word lost, next word sent cleanly
    base = pops;
    push(8'h33);
    push(8'h6E);
    wait_pop(base + 1, 50);
    repeat (26) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_busy", busy, 0);
    chk("arst_rd", fifo_rd, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_done(300);
    chk("arst_pops", pops, base + 2);
    chk("arst_drained", wp - rp, 0);

`ifdef AUCOHL_FIFO_TX_PARITY_EN
    // parity bits 0 (0xA5) and 1 (0x07), 44-cycle frames
    base = pops;
    push(8'hA5);
    push(8'h07);
    wait_done(400);
    chk("par_pops", pops, base + 2);
    chk("par_gap", last_pop - prev_pop, 45);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
